// File: rtl/cpu_types_pkg.sv
// Shared types for the request sequencer that sits between the control unit and the caches.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } req_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: turns control-unit fetch/load/store/halt intent plus cache
// hits into memory enables, PC advance, sticky halt/error and saturating perf counters.
//
//  state | meaning
//  FETCH | instruction fetch in flight; retire non-memory instructions on ihit
//  DATA  | registered load/store held on the bus until dhit
//  HALT  | everything idle; only reset leaves
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int PERF_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iread,
    input  logic              dread,
    input  logic              dwrite,
    input  logic              halt,
    input  logic              ihit,
    input  logic              dhit,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              pc_en,
    output logic              halt_out,
    output logic              err,
    output logic [PERF_W-1:0] instr_count,
    output logic [PERF_W-1:0] stall_count
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

    req_state_t        state, state_nx;
    logic              set_rd, set_wr, set_err, set_halt, stall;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        imemREN  = 1'b0;
        pc_en    = 1'b0;
        set_rd   = 1'b0;
        set_wr   = 1'b0;
        set_err  = 1'b0;
        set_halt = 1'b0;
        stall    = 1'b0;
        case (state)
            FETCH: begin
                imemREN = iread;
                stall   = iread & ~ihit;
                if (ihit) begin
                    // halt outranks any memory op; a store outranks a simultaneous load
                    if (halt) begin
                        state_nx = HALT;
                        set_halt = 1'b1;
                    end else if (dwrite) begin
                        state_nx = DATA;
                        set_wr   = 1'b1;
                        set_err  = dread;
                    end else if (dread) begin
                        state_nx = DATA;
                        set_rd   = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DATA: begin
                stall = ~dhit;
                if (dhit) begin
                    pc_en    = 1'b1;
                    state_nx = FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_err = 1'b1;
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
        if (!nRST) begin
            imemREN = 1'b0;
            pc_en   = 1'b0;
        end
    end

    // Timeout down-counter: reloaded outside DATA, terminal count flags the error once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state != DATA) begin
            wait_cnt <= WAIT_LOAD;
        end else if (!dhit && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            halt_out <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (set_rd || set_wr) begin
                dmemREN <= set_rd;
                dmemWEN <= set_wr;
            end else if ((state == DATA) && dhit) begin
                dmemREN <= 1'b0;
                dmemWEN <= 1'b0;
            end
            if (set_halt) begin
                halt_out <= 1'b1;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(PERF_W)) u_instr_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (pc_en),
        .clr  (1'b0),
        .q    (instr_count)
    );

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (stall),
        .clr  (1'b0),
        .q    (stall_count)
    );

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: vector table, hand-written corner sequences, then random
// traffic against a cycle-level behavioural model.
module tb_request_unit;

    localparam int TO  = 4;
    localparam int WA  = 8;
    localparam int WS  = 2;

    logic CLK = 1'b0;
    logic nRST, iread, dread, dwrite, halt, ihit, dhit;

    logic          imem_a, dren_a, dwen_a, pc_a, ho_a, err_a;
    logic [WA-1:0] ic_a, sc_a;
    logic          imem_s, dren_s, dwen_s, pc_s, ho_s, err_s;
    logic [WS-1:0] ic_s, sc_s;

    request_unit #(.PERF_W(WA), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST), .iread(iread), .dread(dread), .dwrite(dwrite),
        .halt(halt), .ihit(ihit), .dhit(dhit), .imemREN(imem_a), .dmemREN(dren_a),
        .dmemWEN(dwen_a), .pc_en(pc_a), .halt_out(ho_a), .err(err_a),
        .instr_count(ic_a), .stall_count(sc_a)
    );

    request_unit #(.PERF_W(WS), .TIMEOUT(TO)) dut_s (
        .CLK(CLK), .nRST(nRST), .iread(iread), .dread(dread), .dwrite(dwrite),
        .halt(halt), .ihit(ihit), .dhit(dhit), .imemREN(imem_s), .dmemREN(dren_s),
        .dmemWEN(dwen_s), .pc_en(pc_s), .halt_out(ho_s), .err(err_s),
        .instr_count(ic_s), .stall_count(sc_s)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 fetch, 1 load pending, 2 store pending, 3 halted.
    int      m_mode, m_wait;
    logic    m_err, m_ho;
    longint  m_ic, m_sc;

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_err = 1'b0; m_ho = 1'b0; m_ic = 0; m_sc = 0;
    endtask

    function automatic logic m_pc();
        return nRST && ((m_mode == 0 && ihit && !halt && !dread && !dwrite) ||
                        ((m_mode == 1 || m_mode == 2) && dhit));
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint top = (longint'(1) << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_step();
        if (!nRST) begin
            model_reset();
        end else begin
            if (m_pc()) m_ic++;
            if ((m_mode == 0 && iread && !ihit) || ((m_mode == 1 || m_mode == 2) && !dhit))
                m_sc++;
            case (m_mode)
                0: if (ihit) begin
                    if (halt) begin
                        m_mode = 3; m_ho = 1'b1;
                    end else if (dwrite) begin
                        m_mode = 2; m_wait = 0;
                        if (dread) m_err = 1'b1;
                    end else if (dread) begin
                        m_mode = 1; m_wait = 0;
                    end
                end
                1, 2: if (dhit) begin
                    m_mode = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TO) m_err = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic set_in(input logic [6:0] v);
        {nRST, iread, dread, dwrite, halt, ihit, dhit} = v;
        if (!nRST) model_reset();
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_model(input string tg);
        chk({tg, ".imem"}, imem_a, nRST && m_mode == 0 && iread);
        chk({tg, ".dren"}, dren_a, m_mode == 1);
        chk({tg, ".dwen"}, dwen_a, m_mode == 2);
        chk({tg, ".pc"},   pc_a,   m_pc());
        chk({tg, ".halt"}, ho_a,   m_ho);
        chk({tg, ".err"},  err_a,  m_err);
        chk({tg, ".ic"},   ic_a,   sat(m_ic, WA));
        chk({tg, ".sc"},   sc_a,   sat(m_sc, WA));
        chk({tg, ".ic_s"}, ic_s,   sat(m_ic, WS));
        chk({tg, ".sc_s"}, sc_s,   sat(m_sc, WS));
    endtask

    typedef struct {
        logic [6:0] in;   // {nRST, iread, dread, dwrite, halt, ihit, dhit}
        logic [5:0] exp;  // {imemREN, dmemREN, dmemWEN, pc_en, halt_out, err}
    } vec_t;

    vec_t tv[14];

    initial begin
        tv[0]  = '{7'b0_1000_10, 6'b000000};  // held in reset
        tv[1]  = '{7'b1_1000_10, 6'b100100};  // ALU op retires on ihit
        tv[2]  = '{7'b1_1000_00, 6'b100000};  // fetch stall
        tv[3]  = '{7'b1_1100_10, 6'b100000};  // load issued
        tv[4]  = '{7'b1_1000_10, 6'b010000};  // ihit ignored in DATA
        tv[5]  = '{7'b1_1000_00, 6'b010000};
        tv[6]  = '{7'b1_1000_00, 6'b010000};
        tv[7]  = '{7'b1_1000_01, 6'b010100};  // load completes
        tv[8]  = '{7'b1_1110_10, 6'b100000};  // load+store conflict
        tv[9]  = '{7'b1_1000_01, 6'b001101};  // store wins, err set
        tv[10] = '{7'b1_1000_11, 6'b100101};  // dhit ignored in FETCH
        tv[11] = '{7'b1_1011_10, 6'b100001};  // halt beats store
        tv[12] = '{7'b1_1000_10, 6'b000011};
        tv[13] = '{7'b1_1100_11, 6'b000011};  // halted: ignores everything

        model_reset();
        set_in(7'b0);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 14; i++) begin
            set_in(tv[i].in);
            #2;
            chk($sformatf("vec%0d.out", i), {imem_a, dren_a, dwen_a, pc_a, ho_a, err_a}, tv[i].exp);
            tick();
        end
        chk("tbl.instr", ic_a, 4);
        chk("tbl.stall", sc_a, 4);
        chk("tbl.instr_sat", ic_s, 3);

        // store with dhit withheld past the timeout
        set_in(7'b0); tick();
        set_in(7'b1_1010_10); #2;
        chk("to.issue_pc", pc_a, 0);
        tick();
        for (int k = 1; k <= 6; k++) begin
            set_in(7'b1_0000_00); #2;
            chk($sformatf("to.wen%0d", k), dwen_a, 1);
            chk($sformatf("to.err%0d", k), err_a, (k > TO) ? 1 : 0);
            tick();
        end
        set_in(7'b1_1000_01); #2;
        chk("to.pc", pc_a, 1);
        chk("to.stall", sc_a, 6);
        tick();
        set_in(7'b1_1000_00); #2;
        chk("to.fetch_imem", imem_a, 1);
        chk("to.wen_clr", dwen_a, 0);
        chk("to.instr", ic_a, 1);
        tick();

        // reset while a load waits
        set_in(7'b1_1100_10); tick();
        set_in(7'b1_0000_00); #2;
        chk("rst.ren_pre", dren_a, 1);
        #1;
        set_in(7'b0_0000_01);
        #1;
        chk("rst.ren", dren_a, 0);
        chk("rst.pc", pc_a, 0);
        chk("rst.err", err_a, 0);
        chk("rst.instr", ic_a, 0);
        chk("rst.stall", sc_a, 0);
        tick();

        // saturation with 5 retirements
        for (int k = 0; k < 5; k++) begin
            set_in(7'b1_1000_10); tick();
        end
        set_in(7'b1_0000_00); #2;
        chk("sat.instr_s", ic_s, 3);
        chk("sat.instr_a", ic_a, 5);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [6:0] v;
            v[6] = ($urandom_range(0, 99) >= 2);
            v[5] = ($urandom_range(0, 9) != 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 3) == 0);
            v[2] = ($urandom_range(0, 99) < 3);
            v[1] = ($urandom_range(0, 1) == 0);
            v[0] = ($urandom_range(0, 9) < 3);
            set_in(v);
            #2;
            chk_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
